mem_sram_stage: RTL and testbench
=================================

Name: mem_sram_stage

Overview:
- Parametrised memory-stage block between EX/MEM and MEM/WB pipeline registers.
- Converts one DATA_W-bit load/store per instruction into one or more narrower SRAM beats with programmable wait states.
- Holds `ready` low while busy so the hazard/stall logic freezes the pipeline.
- Generalises the fixed 32-bit single-width SRAM path to arbitrary word/SRAM width ratios, an address base offset, and an output-enable strobe.

Parameters:
- DATA_W, 32: pipeline word width; multiple of 8.
- SRAM_DW, 16: SRAM data bus width; must divide DATA_W; BEATS = DATA_W/SRAM_DW.
- SRAM_AW, 18: SRAM address width.
- WAIT_CYCLES, 5: cycles per SRAM beat; minimum 1.
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.

Ports:
- clk  in  1  pipeline clock; also used for the SRAM interface.
- rst  in  1  asynchronous reset, active-low.
- wr_en  in  1  store request (MEM_W_EN).
- rd_en  in  1  load request (MEM_R_EN).
- address  in  32  byte address from ALU result.
- write_data  in  DATA_W  store data (Val_Rm).
- read_data  out  DATA_W  load result, registered.
- ready  out  1  high = stage can advance; low = stall pipeline.
- addr_err  out  1  out-of-range access flag (see Optional Feature).
- sram_dq  inout  SRAM_DW  SRAM data bus.
- sram_addr  out  SRAM_AW  SRAM address.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE, beat=0, wait counter=0, read_data=0.
  - sram_addr=0, sram_we_n=1, sram_oe_n=1, sram_dq=Z, addr_err=0.
  - Reset mid-access aborts immediately; no partial-completion guarantee.
- States:
  - IDLE: ready = ~(wr_en|rd_en), combinational. On a request, latch address, write_data and op, then go to ACCESS.
  - ACCESS: runs BEATS×WAIT_CYCLES cycles; ready=0.
  - DONE: lasts one cycle; ready=1; requests ignored; returns to IDLE.
- If wr_en and rd_en are both high, the request is treated as a store.
- Address mapping:
  - word index = (address − BASE_ADDR) >> log2(DATA_W/8).
  - sram_addr = word index × BEATS + beat, truncated to SRAM_AW.
  - Low bits of address below word alignment are ignored.
- Beat order: beat 0 carries bits [SRAM_DW−1:0] (little-endian), ascending.
- Write beat:
  - sram_dq driven with the current slice for all WAIT_CYCLES cycles.
  - sram_we_n=0 for the first WAIT_CYCLES−1 cycles and 1 in the last cycle (address/data hold). When WAIT_CYCLES=1, we_n is low for that single cycle.
- Read beat:
  - sram_oe_n=0 and sram_dq=Z for the whole beat.
  - Slice sampled into read_data on the clock edge ending the beat's last cycle.
  - read_data is fully updated on entry to DONE and holds until the next load completes; stores do not alter it.
- Latency: ready is low for exactly 1 + BEATS×WAIT_CYCLES cycles per access, 11 at defaults.
- Beat and wait counters wrap to 0 after the final beat. There is no overlap between accesses.
- In IDLE with no request: sram_we_n=1, sram_oe_n=1, sram_dq=Z, sram_addr holds its last value.

Optional Feature:
- Macro: MEM_SRAM_ADDR_CHECK_EN.
- Defined:
  - A request is out of range if address < BASE_ADDR or word index ≥ 2^SRAM_AW/BEATS.
  - An out-of-range request skips ACCESS and goes IDLE→DONE, with ready low for 1 cycle and no SRAM strobes.
  - addr_err=1 during that DONE cycle; read_data is set to 0 for an out-of-range load.
- Not defined: addr_err tied 0; no range check; address truncated as above.

Test Plan:
- Store 0xDEADBEEF at address 1024 (defaults) → sram_addr 0 gets 0xBEEF, then sram_addr 1 gets 0xDEAD; we_n low 4 cycles per beat; ready low 11 cycles, then high 1 cycle.
- Load from 1024 after that store → read_data=0xDEADBEEF on entering DONE; sram_oe_n low 10 cycles; sram_we_n stays 1 throughout.
- Back-to-back store at 1028, then load at 1028, with requests held until ready → second access starts the cycle after DONE; sram_addr 2/3 used; read_data=stored value; no request lost or duplicated.
- wr_en=rd_en=1 at 1032 with data 0x12345678 → treated as a store; read_data unchanged.
- rst pulsed low mid-write (beat 1, cycle 2) → sram_we_n=1, sram_dq=Z, ready=1 immediately; after release the next load completes normally.
- With MEM_SRAM_ADDR_CHECK_EN, load at 1020 → ready low 1 cycle, addr_err=1 in DONE, read_data=0, no SRAM strobes. Without the macro, addr_err stays 0.

Source files
------------

// File: rtl/mem_sram_stage_if.sv
// Pipeline-side load/store bus of the SRAM memory stage.
// The master drives requests and the slave (the stage) returns data and status.
interface mem_sram_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;
  logic              addr_err;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready, addr_err
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready, addr_err
  );
endinterface

// File: rtl/mem_sram_stage.sv
// MEM-stage SRAM sequencer: splits each DATA_W load/store into SRAM_DW beats with wait states.
// Optional out-of-range detection is enabled by defining MEM_SRAM_ADDR_CHECK_EN.
module mem_sram_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SRAM_DW     = 16,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_sram_stage_if.slave    bus,
  inout  wire  [SRAM_DW-1:0] sram_dq_io,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic               sram_we_n_o,
  output logic               sram_oe_n_o
);

  localparam int unsigned BEATS   = DATA_W / SRAM_DW;
  localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WAIT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]         state_q,     state_d;
  logic [BEAT_W-1:0]  beat_q,      beat_d;
  logic [WAIT_W-1:0]  wait_q,      wait_d;
  logic               op_wr_q,     op_wr_d;
  logic [DATA_W-1:0]  wdata_q,     wdata_d;
  logic [DATA_W-1:0]  rbuf_q,      rbuf_d;
  logic [DATA_W-1:0]  read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic               we_n_q,      we_n_d;
  logic               oe_n_q,      oe_n_d;
  logic               dq_oe_q,     dq_oe_d;
  logic [SRAM_DW-1:0] dq_out_q,    dq_out_d;

  logic               req_c;
  logic               go_c;
  logic [31:0]        offset_c;
  logic [31:0]        word_idx_c;
  logic [SRAM_AW-1:0] first_addr_c;

  // Word index relative to the SRAM window; sub-word address bits drop out in the shift
  assign req_c        = bus.wr_en | bus.rd_en;
  assign offset_c     = bus.address - 32'(BASE_ADDR);
  assign word_idx_c   = offset_c >> BYTE_SH;
  assign first_addr_c = SRAM_AW'(word_idx_c * 32'(BEATS));

`ifdef MEM_SRAM_ADDR_CHECK_EN
  localparam logic [63:0] WORD_LIMIT = (64'd1 << SRAM_AW) / 64'(BEATS);

  logic oor_c;
  logic err_q, err_d;

  assign oor_c = (bus.address < 32'(BASE_ADDR)) || ({32'd0, word_idx_c} >= WORD_LIMIT);
  assign go_c  = req_c & ~oor_c;
`else
  assign go_c  = req_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      op_wr_q     <= 1'b0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
`ifdef MEM_SRAM_ADDR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      op_wr_q     <= op_wr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
`ifdef MEM_SRAM_ADDR_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // Strobes are computed for the cycle being entered so the SRAM pins come straight from flops
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    op_wr_d     = op_wr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
`ifdef MEM_SRAM_ADDR_CHECK_EN
    err_d       = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          op_wr_d = bus.wr_en;
          wdata_d = bus.write_data;
          beat_d  = '0;
          wait_d  = '0;
        end
        if (go_c) begin
          state_d     = S_ACCESS;
          sram_addr_d = first_addr_c;
          we_n_d      = ~bus.wr_en;
          oe_n_d      = bus.wr_en;
          dq_oe_d     = bus.wr_en;
          dq_out_d    = bus.write_data[SRAM_DW-1:0];
        end
`ifdef MEM_SRAM_ADDR_CHECK_EN
        else if (req_c) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!bus.wr_en) read_data_d = '0;
        end
`endif
      end

      S_ACCESS: begin
        dq_oe_d = op_wr_q;
        oe_n_d  = op_wr_q;
        if (wait_q != LAST_WAIT) begin
          wait_d = wait_q + WAIT_W'(1);
          // Final wait cycle of a write beat releases we_n while address/data hold
          we_n_d = ~op_wr_q | (WAIT_W'(wait_q + WAIT_W'(1)) == LAST_WAIT);
        end else begin
          wait_d = '0;
          if (!op_wr_q) rbuf_d[int'(beat_q) * SRAM_DW +: SRAM_DW] = sram_dq_io;
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
            beat_d  = '0;
            we_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            if (!op_wr_q) read_data_d = rbuf_d;
          end else begin
            beat_d      = beat_q + BEAT_W'(1);
            sram_addr_d = sram_addr_q + SRAM_AW'(1);
            we_n_d      = ~op_wr_q;
            dq_out_d    = wdata_q[(int'(beat_q) + 1) * SRAM_DW +: SRAM_DW];
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ready is combinational in IDLE so a new request stalls the pipeline in the same cycle
  assign bus.ready     = (state_q == S_IDLE) ? ~req_c : (state_q == S_DONE);
  assign bus.read_data = read_data_q;
`ifdef MEM_SRAM_ADDR_CHECK_EN
  assign bus.addr_err  = err_q;
`else
  assign bus.addr_err  = 1'b0;
`endif

  assign sram_dq_io  = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
  assign sram_addr_o = sram_addr_q;
  assign sram_we_n_o = we_n_q;
  assign sram_oe_n_o = oe_n_q;

endmodule

// File: tb/tb_mem_sram_stage.sv
// Self-checking bench for mem_sram_stage at default parameters with a behavioural SRAM.
// Honours MEM_SRAM_ADDR_CHECK_EN when the design is built with it.
module tb_mem_sram_stage;

  localparam int unsigned DW  = 32;
  localparam int unsigned SDW = 16;
  localparam int unsigned SAW = 18;

  logic clk;
  logic rst_n;

  wire  [SDW-1:0] sram_dq;
  logic [SAW-1:0] sram_addr;
  logic           sram_we_n;
  logic           sram_oe_n;

  mem_sram_stage_if #(.DATA_W(DW)) bus ();

  mem_sram_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_dq_io (sram_dq),
    .sram_addr_o(sram_addr),
    .sram_we_n_o(sram_we_n),
    .sram_oe_n_o(sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous-read SRAM, written on clock edges while we_n is low
  logic [SDW-1:0] sram_mem [0:(1<<SAW)-1];
  assign sram_dq = sram_oe_n ? {SDW{1'bz}} : sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd;
  logic [31:0] ref_mem [int];

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Issues one request at a negedge of an IDLE cycle and measures it until DONE
  task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, input bit release_req,
                           output int rdy_low, output int we_low, output int oe_low,
                           output logic [31:0] rd_val, output logic err);
    bit seen;
    bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
    rdy_low = 0; we_low = 0; oe_low = 0; seen = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (bus.ready) begin seen = 1; break; end
      rdy_low++;
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL access_timeout got ready=0 exp ready=1 within 64 cycles"); end
    rd_val = bus.read_data;
    err    = bus.addr_err;
    if (release_req) begin bus.wr_en = 1'b0; bus.rd_en = 1'b0; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b exp 1", sram_we_n); end
    checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n got %b exp 1", sram_oe_n); end
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", sram_addr); end
    checks++; if (bus.read_data !== '0) begin errors++; $display("FAIL reset_read_data got %h exp 0", bus.read_data); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b exp 0", bus.addr_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_rd = '0;
  endtask

  task automatic test_store_load();
    int rl, wl, ol; logic [31:0] rv; logic er;
    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b1, rl, wl, ol, rv, er);
    ref_mem[0] = 32'hDEADBEEF;
    checks++; if (rl != 11) begin errors++; $display("FAIL store_ready_low got %0d exp 11", rl); end
    checks++; if (wl != 8) begin errors++; $display("FAIL store_we_low got %0d exp 8", wl); end
    checks++; if (ol != 0) begin errors++; $display("FAIL store_oe_low got %0d exp 0", ol); end
    checks++; if (rv !== exp_rd) begin errors++; $display("FAIL store_keeps_rd got %h exp %h", rv, exp_rd); end
    checks++; if (sram_mem[0] !== 16'hBEEF) begin errors++; $display("FAIL store_beat0 got %h exp BEEF", sram_mem[0]); end
    checks++; if (sram_mem[1] !== 16'hDEAD) begin errors++; $display("FAIL store_beat1 got %h exp DEAD", sram_mem[1]); end
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, rl, wl, ol, rv, er);
    exp_rd = ref_mem[0];
    checks++; if (rl != 11) begin errors++; $display("FAIL load_ready_low got %0d exp 11", rl); end
    checks++; if (ol != 10) begin errors++; $display("FAIL load_oe_low got %0d exp 10", ol); end
    checks++; if (wl != 0) begin errors++; $display("FAIL load_we_low got %0d exp 0", wl); end
    checks++; if (rv !== exp_rd) begin errors++; $display("FAIL load_data got %h exp %h", rv, exp_rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_addr_err got %b exp 0", er); end
  endtask

  task automatic test_back_to_back();
    int rl, wl, ol; logic [31:0] rv, d; logic er;
    d = $urandom;
    do_access(1'b1, 1'b0, 32'd1028, d, 1'b0, rl, wl, ol, rv, er);
    ref_mem[1] = d;
    checks++; if (rl != 11) begin errors++; $display("FAIL b2b_store_ready_low got %0d exp 11", rl); end
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1, rl, wl, ol, rv, er);
    exp_rd = ref_mem[1];
    checks++; if (rl != 11) begin errors++; $display("FAIL b2b_load_ready_low got %0d exp 11", rl); end
    checks++; if (rv !== exp_rd) begin errors++; $display("FAIL b2b_load_data got %h exp %h", rv, exp_rd); end
    checks++; if (sram_mem[2] !== d[15:0]) begin errors++; $display("FAIL b2b_sram2 got %h exp %h", sram_mem[2], d[15:0]); end
    checks++; if (sram_mem[3] !== d[31:16]) begin errors++; $display("FAIL b2b_sram3 got %h exp %h", sram_mem[3], d[31:16]); end
    #1;
    checks++; if (bus.ready !== 1'b1 || sram_oe_n !== 1'b1 || sram_we_n !== 1'b1) begin
      errors++; $display("FAIL b2b_no_dup got ready=%b oe_n=%b we_n=%b exp 1 1 1", bus.ready, sram_oe_n, sram_we_n);
    end
    @(negedge clk);
  endtask

  task automatic test_both_enables();
    int rl, wl, ol; logic [31:0] rv; logic er;
    do_access(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b1, rl, wl, ol, rv, er);
    ref_mem[2] = 32'h12345678;
    checks++; if (wl != 8 || ol != 0) begin errors++; $display("FAIL both_strobes got we=%0d oe=%0d exp 8 0", wl, ol); end
    checks++; if (rv !== exp_rd) begin errors++; $display("FAIL both_rd_unchanged got %h exp %h", rv, exp_rd); end
    checks++; if (sram_mem[4] !== 16'h5678 || sram_mem[5] !== 16'h1234) begin
      errors++; $display("FAIL both_sram got %h_%h exp 1234_5678", sram_mem[5], sram_mem[4]);
    end
  endtask

  task automatic test_reset_mid_write();
    int rl, wl, ol; logic [31:0] rv; logic er;
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = 32'd1040; bus.write_data = 32'hCAFEF00D;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL midwr_we_active got %b exp 0", sram_we_n); end
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL midwr_we_n got %b exp 1", sram_we_n); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midwr_ready got %b exp 1", bus.ready); end
    checks++; if (bus.read_data !== '0) begin errors++; $display("FAIL midwr_read_data got %h exp 0", bus.read_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, rl, wl, ol, rv, er);
    exp_rd = ref_mem[0];
    checks++; if (rl != 11) begin errors++; $display("FAIL post_rst_ready_low got %0d exp 11", rl); end
    checks++; if (rv !== exp_rd) begin errors++; $display("FAIL post_rst_load got %h exp %h", rv, exp_rd); end
  endtask

  task automatic test_random();
    int rl, wl, ol; logic [31:0] rv, d, addr; logic er, wr, rd; int w; bit rel;
    for (int n = 0; n < 24; n++) begin
      w    = 64 + int'($urandom_range(0, 7));
      addr = 32'd1024 + 32'(w * 4) + 32'($urandom_range(0, 3));
      d    = $urandom;
      wr   = ($urandom_range(0, 1) == 1) || !ref_mem.exists(w);
      rd   = !wr || ($urandom_range(0, 3) == 0);
      rel  = (n == 23) || ($urandom_range(0, 1) == 1);
      do_access(wr, rd, addr, d, rel, rl, wl, ol, rv, er);
      if (wr) ref_mem[w] = d;
      else    exp_rd = ref_mem[w];
      checks++; if (rl != 11) begin errors++; $display("FAIL rand_ready_low op %0d got %0d exp 11", n, rl); end
      checks++; if (wl != (wr ? 8 : 0) || ol != (wr ? 0 : 10)) begin
        errors++; $display("FAIL rand_strobes op %0d got we=%0d oe=%0d wr=%b", n, wl, ol, wr);
      end
      checks++; if (rv !== exp_rd) begin errors++; $display("FAIL rand_read_data op %0d got %h exp %h", n, rv, exp_rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL rand_addr_err op %0d got %b exp 0", n, er); end
      if (rel) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_addr_check();
    int rl, wl, ol; logic [31:0] rv; logic er;
`ifdef MEM_SRAM_ADDR_CHECK_EN
    do_access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b1, rl, wl, ol, rv, er);
    exp_rd = '0;
    checks++; if (rl != 1) begin errors++; $display("FAIL oor_ready_low got %0d exp 1", rl); end
    checks++; if (wl != 0 || ol != 0) begin errors++; $display("FAIL oor_strobes got we=%0d oe=%0d exp 0 0", wl, ol); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_addr_err got %b exp 1", er); end
    checks++; if (rv !== exp_rd) begin errors++; $display("FAIL oor_read_data got %h exp 0", rv); end
`endif
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, rl, wl, ol, rv, er);
    exp_rd = ref_mem[0];
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL inrange_addr_err got %b exp 0", er); end
    checks++; if (rv !== exp_rd) begin errors++; $display("FAIL inrange_load got %h exp %h", rv, exp_rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_both_enables();
    test_reset_mid_write();
    test_random();
    test_addr_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
